// File: rtl/lfsr_run_ctrl.sv
// -----------------------------------------------------------------------------
// lfsr_run_ctrl
// Sequences one complete period of an external W-bit LFSR. It seeds the LFSR
// and clears the companion ones-counter. It then steps both until the LFSR
// returns to SEED, and latches the ones-count and the period length. Lock-up
// (all-zero state) and runaway (no return within 2^W-1 steps) are reported
// through a sticky error flag. A run can be paused or aborted.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_start      run request, only honoured in IDLE
//   i_abort      cancel an active run (wins over start in IDLE)
//   i_pause      freeze stepping while in RUN
//   i_lfsr_q     current LFSR state
//   i_count_q    current ones-counter value
//   o_lfsr_load  load SEED into the LFSR this cycle
//   o_lfsr_seed  constant SEED
//   o_lfsr_en    advance the LFSR this cycle
//   o_cnt_clr    clear the counter this cycle
//   o_cnt_en     counter increment enable (MSB of the presented LFSR state)
//   o_busy       high while in LOAD or RUN
//   o_done       one-cycle pulse on successful completion
//   o_err        sticky fault flag, cleared by the next accepted start
//   o_result     ones-count of the last good run
//   o_period     step count of the last good run
// -----------------------------------------------------------------------------
module lfsr_run_ctrl #(
  parameter int unsigned    W    = 22,
  parameter logic [W-1:0]   SEED = {W{1'b1}}
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic         i_pause,
  input  logic [W-1:0] i_lfsr_q,
  input  logic [W-1:0] i_count_q,
  output logic         o_lfsr_load,
  output logic [W-1:0] o_lfsr_seed,
  output logic         o_lfsr_en,
  output logic         o_cnt_clr,
  output logic         o_cnt_en,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err,
  output logic [W-1:0] o_result,
  output logic [W-1:0] o_period
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [W-1:0] STEP_ZERO = {W{1'b0}};
  localparam logic [W-1:0] STEP_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] STEP_MAX  = {W{1'b1}};

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_step_cnt;
  logic [W-1:0] w_step_nxt;
  logic         r_busy;
  logic         r_done;
  logic         r_err;
  logic [W-1:0] r_result;
  logic [W-1:0] r_period;

  logic         w_lfsr_load;
  logic         w_cnt_clr;
  logic         w_lfsr_en;
  logic         w_cnt_en;
  logic         w_set_err;
  logic         w_clr_err;
  logic         w_latch;

  // Next-state, step counter and strobe decode. Strobes depend only on the
  // registered state, the registered step count and inputs that are themselves
  // register outputs, so they settle well before the next sampling edge.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step_cnt;
    w_lfsr_load = 1'b0;
    w_cnt_clr   = 1'b0;
    w_lfsr_en   = 1'b0;
    w_cnt_en    = 1'b0;
    w_set_err   = 1'b0;
    w_clr_err   = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          w_state_nxt = S_LOAD;
          w_clr_err   = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        w_lfsr_load = 1'b1;
        w_cnt_clr   = 1'b1;
        w_step_nxt  = STEP_ZERO;
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (i_lfsr_q == STEP_ZERO) begin
          w_state_nxt = S_ERROR;
          w_set_err   = 1'b1;
        end else if ((r_step_cnt != STEP_ZERO) && (i_lfsr_q == SEED)) begin
          // Back at SEED: the counter already holds the last MSB, so latch now.
          w_state_nxt = S_DONE;
          w_latch     = 1'b1;
        end else if (r_step_cnt == STEP_MAX) begin
          // A maximal LFSR would have returned to SEED by now.
          w_state_nxt = S_ERROR;
          w_set_err   = 1'b1;
        end else if (i_pause) begin
          w_state_nxt = S_RUN;
        end else begin
          w_lfsr_en  = 1'b1;
          w_cnt_en   = i_lfsr_q[W-1];
          w_step_nxt = r_step_cnt + STEP_ONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      S_ERROR: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register, step counter and registered status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_step_cnt <= STEP_ZERO;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_result   <= STEP_ZERO;
      r_period   <= STEP_ZERO;
    end else begin
      r_state    <= w_state_nxt;
      r_step_cnt <= w_step_nxt;
      r_busy     <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN);
      r_done     <= (w_state_nxt == S_DONE);
      if (w_clr_err) begin
        r_err <= 1'b0;
      end else if (w_set_err) begin
        r_err <= 1'b1;
      end else begin
        r_err <= r_err;
      end
      // Latched on entry to DONE so the values are valid alongside o_done;
      // the counter does not move while in DONE.
      if (w_latch) begin
        r_result <= i_count_q;
        r_period <= r_step_cnt;
      end else begin
        r_result <= r_result;
        r_period <= r_period;
      end
    end
  end

  assign o_lfsr_load = w_lfsr_load;
  assign o_cnt_clr   = w_cnt_clr;
  assign o_lfsr_en   = w_lfsr_en;
  assign o_cnt_en    = w_cnt_en;
  assign o_lfsr_seed = SEED;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_result    = r_result;
  assign o_period    = r_period;

endmodule
